instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Instruction-fetch stage for the 5-stage MIPS pipeline. It owns the PC and issues single-outstanding requests to instruction memory. It produces the Instruction and PCPlus4 words that the IF/ID pipeline register latches every cycle. It handles pipeline stalls by holding its outputs, and branch redirects by flushing to a NOP bubble and discarding stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word driven as a bubble (MIPS sll $0,$0,0)

Ports:
CLOCK  input  1  system clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
STALL  input  1  hazard unit: decode cannot accept; hold outputs
BRANCH_TAKEN  input  1  one-cycle redirect pulse from branch resolution
BRANCH_TARGET  input  32  redirect address; bits [1:0] ignored (forced 00)
IMEM_REQ  output  1  one-cycle fetch request strobe
IMEM_ADDR  output  32  fetch address; stable from IMEM_REQ until IMEM_VALID
IMEM_DATA  input  32  instruction word; valid only when IMEM_VALID=1
IMEM_VALID  input  1  response strobe; never in the same cycle as IMEM_REQ
Instruction_Out  output  32  instruction to IF/ID register
PCPlus4_Out  output  32  PC+4 of Instruction_Out
VALID_Out  output  1  1 = Instruction_Out is a real instruction, 0 = bubble

Behaviour:
- Reset and clock: one clock, CLOCK. RESET is synchronous and active-high.
- On RESET=1 at posedge:
  - PC=RESET_PC, state=FETCH, discard=0, hold buffer cleared.
  - IMEM_REQ=0, Instruction_Out=NOP_WORD, PCPlus4_Out=0, VALID_Out=0.
  - RESET mid-WAIT abandons the request. The memory is reset on the same RESET, so no stray response is expected.
- All outputs are registered, except IMEM_REQ/IMEM_ADDR, which decode from the state/PC registers.
- State FETCH:
  - IMEM_REQ=1 and IMEM_ADDR=PC for exactly one cycle.
  - Next state is WAIT.
- State WAIT: wait for IMEM_VALID.
  - If IMEM_VALID and discard=1: clear discard; go to FETCH (PC already holds the target).
  - If IMEM_VALID and STALL=1: capture IMEM_DATA into the hold buffer; go to HOLD.
  - If IMEM_VALID and STALL=0: Instruction_Out<=IMEM_DATA, PCPlus4_Out<=PC+4, VALID_Out<=1, PC<=PC+4; go to FETCH.
- State HOLD:
  - While STALL=1, stay in HOLD and keep the buffer.
  - When STALL=0, deliver the buffer as above; PC<=PC+4; go to FETCH.
- Output hold and bubble rules (cycles with no delivery):
  - STALL=1: Instruction_Out, PCPlus4_Out and VALID_Out hold their values, so IF/ID re-latches the same word.
  - STALL=0: outputs become NOP_WORD, PCPlus4_Out unchanged, VALID_Out=0.
- BRANCH_TAKEN=1 has highest priority after RESET and overrides STALL:
  - PC<=BRANCH_TARGET with bits [1:0]=00.
  - Instruction_Out<=NOP_WORD and VALID_Out<=0 (flush).
  - In FETCH or HOLD: go to FETCH and drop the buffer.
  - In WAIT with IMEM_VALID=0: set discard=1 and stay in WAIT.
  - In WAIT with IMEM_VALID=1 in the same cycle: drop the response and go to FETCH.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Latency and throughput:
  - With a 1-cycle memory: IMEM_REQ at cycle t, IMEM_VALID at t+1, Instruction_Out visible after posedge t+2.
  - Sustained rate is 1 instruction per 2 cycles.

Optional Feature:
- Macro IF_PERF_COUNTERS_EN.
- When defined, add two outputs:
  - FETCH_COUNT (32): increments on every delivery with VALID_Out<=1.
  - BUBBLE_COUNT (32): increments on every cycle that drives a NOP bubble with STALL=0.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package:
  - state encoding: FETCH=2'd0, WAIT=2'd1, HOLD=2'd2
  - NOP_WORD default
  - RESET_PC default
  - PC increment constant 4
- One natural sub-module, fetch_hold_buffer: a 32-bit register with load/clear/valid, used for the HOLD state.

Test Plan:
- Reset, then 1-cycle memory returning IMEM_DATA=32'h2008_0005 at PC 0 -> IMEM_ADDR=0 with IMEM_REQ pulse; then Instruction_Out=32'h2008_0005, PCPlus4_Out=4, VALID_Out=1; next IMEM_ADDR=4.
- STALL=1 asserted when a response arrives for PC 8 and held 3 cycles -> state HOLD; outputs unchanged for 3 cycles; after STALL drops, instruction for PC 8 is delivered with PCPlus4_Out=12; no re-fetch of 8.
- BRANCH_TAKEN with BRANCH_TARGET=32'h0000_0043 during WAIT (memory 3-cycle latency) -> bubble output VALID_Out=0; old response discarded; next IMEM_ADDR=32'h0000_0040.
- BRANCH_TAKEN and STALL both high in the same cycle as IMEM_VALID -> response dropped, NOP emitted, PC=target, STALL ignored.
- PC=32'hFFFF_FFFC fetch -> PCPlus4_Out=0; next IMEM_ADDR=0.
- RESET asserted during HOLD -> all outputs at reset values next cycle; first IMEM_ADDR=RESET_PC. With IF_PERF_COUNTERS_EN defined, both counters read 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional perf counters are enabled with IF_PERF_COUNTERS_EN.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_hold_buffer.sv
// Parks one instruction word while decode is stalled.
// Clear wins over load so a redirect always drops the parked word.
module fetch_hold_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        valid
);

  always_ff @(posedge CLOCK) begin
    if (RESET || clear) begin
      data_out <= NOP_WORD_DEF;
      valid    <= 1'b0;
    end else if (load) begin
      data_out <= data_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, one outstanding imem request, stall/redirect.
// Define IF_PERF_COUNTERS_EN to add FETCH_COUNT / BUBBLE_COUNT.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        IMEM_VALID,
  output logic [31:0] Instruction_Out,
  output logic [31:0] PCPlus4_Out,
  output logic        VALID_Out
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] BUBBLE_COUNT
`endif
);

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_inc;
  logic        discard;
  if_id_t      ifid_q;
  logic [31:0] hold_data, dlv_word;
  logic        hold_valid;
  logic        in_wait, in_hold;
  logic        rsp_live, dlv, cap, drop_buf;

  assign pc_inc   = pc_next(pc);
  assign in_wait  = (state == WAIT);
  assign in_hold  = (state == HOLD);
  assign rsp_live = in_wait & IMEM_VALID & ~discard;
  assign dlv      = ~BRANCH_TAKEN & ~STALL &
                    (rsp_live | (in_hold & hold_valid));
  assign cap      = ~BRANCH_TAKEN & STALL & rsp_live;
  assign drop_buf = BRANCH_TAKEN | (in_hold & ~STALL);
  assign dlv_word = in_hold ? hold_data : IMEM_DATA;

  fetch_hold_buffer u_hold (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .load     (cap),
    .clear    (drop_buf),
    .data_in  (IMEM_DATA),
    .data_out (hold_data),
    .valid    (hold_valid)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: state_nxt = BRANCH_TAKEN ? FETCH : WAIT;
      WAIT: begin
        if (IMEM_VALID) state_nxt = cap ? HOLD : FETCH;
      end
      HOLD: begin
        if (BRANCH_TAKEN || !STALL) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IMEM_REQ  = (state == FETCH);
    IMEM_ADDR = pc;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pc           <= RESET_PC;
      discard      <= 1'b0;
      ifid_q.instr <= NOP_WORD;
      ifid_q.pc4   <= 32'h0;
      ifid_q.valid <= 1'b0;
    end else if (BRANCH_TAKEN) begin
      pc           <= BRANCH_TARGET & WORD_MASK;
      // response still in flight: swallow it when it lands
      discard      <= in_wait & ~IMEM_VALID;
      ifid_q.instr <= NOP_WORD;
      ifid_q.valid <= 1'b0;
    end else begin
      if (in_wait && IMEM_VALID) discard <= 1'b0;
      if (dlv) begin
        pc           <= pc_inc;
        ifid_q.instr <= dlv_word;
        ifid_q.pc4   <= pc_inc;
        ifid_q.valid <= 1'b1;
      end else if (!STALL) begin
        ifid_q.instr <= NOP_WORD;
        ifid_q.valid <= 1'b0;
      end
    end
  end

  assign Instruction_Out = ifid_q.instr;
  assign PCPlus4_Out     = ifid_q.pc4;
  assign VALID_Out       = ifid_q.valid;

`ifdef IF_PERF_COUNTERS_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      FETCH_COUNT  <= 32'h0;
      BUBBLE_COUNT <= 32'h0;
    end else begin
      if (dlv)           FETCH_COUNT  <= FETCH_COUNT + 32'd1;
      if (!dlv && !STALL) BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector table, corner sequences,
// then random stall/redirect/latency against a transaction-level model.
module tb_instruction_fetch_unit;

  logic        CLOCK = 1'b0;
  logic        RESET, STALL, BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        IMEM_REQ, IMEM_VALID, VALID_Out;
  logic [31:0] IMEM_ADDR, IMEM_DATA;
  logic [31:0] Instruction_Out, PCPlus4_Out;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] FETCH_COUNT, BUBBLE_COUNT;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

  instruction_fetch_unit dut (
    .CLOCK           (CLOCK),
    .RESET           (RESET),
    .STALL           (STALL),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .IMEM_REQ        (IMEM_REQ),
    .IMEM_ADDR       (IMEM_ADDR),
    .IMEM_DATA       (IMEM_DATA),
    .IMEM_VALID      (IMEM_VALID),
    .Instruction_Out (Instruction_Out),
    .PCPlus4_Out     (PCPlus4_Out),
    .VALID_Out       (VALID_Out)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .FETCH_COUNT     (FETCH_COUNT),
    .BUBBLE_COUNT    (BUBBLE_COUNT)
`endif
  );

  // reference model: request / response / parked-word view
  bit          m_need, m_fly, m_stale, m_held, m_val;
  logic [31:0] m_hw, m_pc, m_ins, m_pc4, m_fc, m_bc;

  // instruction memory
  bit          mem_busy, rand_lat;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_a;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    chk("req",   {31'b0, IMEM_REQ},  {31'b0, m_need});
    chk("addr",  IMEM_ADDR,          m_pc);
    chk("instr", Instruction_Out,    m_ins);
    chk("pc4",   PCPlus4_Out,        m_pc4);
    chk("valid", {31'b0, VALID_Out}, {31'b0, m_val});
`ifdef IF_PERF_COUNTERS_EN
    chk("fetch_count",  FETCH_COUNT,  m_fc);
    chk("bubble_count", BUBBLE_COUNT, m_bc);
`endif
  endtask

  task automatic model_step(input bit rst, input bit stall, input bit br,
                            input logic [31:0] tgt, input bit iv,
                            input logic [31:0] id);
    bit got;
    logic [31:0] w;
    got = 0;
    w = 32'h0;
    if (rst) begin
      m_need = 1; m_fly = 0; m_stale = 0; m_held = 0;
      m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_val = 0;
      m_fc = 0; m_bc = 0;
      return;
    end
    if (br) begin
      if (m_fly && !iv) m_stale = 1;
      else begin m_fly = 0; m_stale = 0; m_need = 1; end
      m_held = 0;
      m_pc = tgt & 32'hFFFF_FFFC;
      m_ins = 32'h0;
      m_val = 0;
      if (!stall) m_bc++;
      return;
    end
    if (m_need) begin
      m_need = 0;
      m_fly = 1;
    end else if (m_fly && iv) begin
      m_fly = 0;
      if (m_stale) begin m_stale = 0; m_need = 1; end
      else if (stall) begin m_held = 1; m_hw = id; end
      else begin got = 1; w = id; end
    end else if (m_held && !stall) begin
      m_held = 0; got = 1; w = m_hw;
    end
    if (got) begin
      m_ins = w; m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_val = 1;
      m_need = 1; m_fc++;
    end else if (!stall) begin
      m_ins = 32'h0; m_val = 0; m_bc++;
    end
  endtask

  // called at a negedge: check, drive memory + inputs, advance one clock
  task automatic tick(input bit rst, input bit stall, input bit br,
                      input logic [31:0] tgt);
    model_cmp();
    IMEM_VALID = 0;
    IMEM_DATA = $urandom;
    if (rst) mem_busy = 0;
    else begin
      if (mem_busy) begin
        if (mem_cnt == 1) begin
          IMEM_VALID = 1; IMEM_DATA = mem_word(mem_a); mem_busy = 0;
        end else mem_cnt--;
      end
      if (IMEM_REQ) begin
        mem_busy = 1; mem_a = IMEM_ADDR;
        mem_cnt = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
    RESET = rst; STALL = stall; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
    model_step(rst, stall, br, tgt, IMEM_VALID, IMEM_DATA);
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 12 && !IMEM_REQ; i++) tick(0, 0, 0, 32'h0);
    chk("wait_req", {31'b0, IMEM_REQ}, 32'h1);
  endtask

  typedef struct {
    bit          stall;
    logic [31:0] e_req, e_addr, e_ins, e_pc4, e_val;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 1, 32'h00, 32'h0,         32'h00, 0};
    tbl[1]  = '{0, 0, 32'h00, 32'h0,         32'h00, 0};
    tbl[2]  = '{0, 1, 32'h04, 32'h2008_0005, 32'h04, 1};
    tbl[3]  = '{0, 0, 32'h04, 32'h0,         32'h04, 0};
    tbl[4]  = '{0, 1, 32'h08, 32'hC0DE_0004, 32'h08, 1};
    tbl[5]  = '{1, 0, 32'h08, 32'h0,         32'h08, 0};
    tbl[6]  = '{1, 0, 32'h08, 32'h0,         32'h08, 0};
    tbl[7]  = '{1, 0, 32'h08, 32'h0,         32'h08, 0};
    tbl[8]  = '{0, 0, 32'h08, 32'h0,         32'h08, 0};
    tbl[9]  = '{0, 1, 32'h0C, 32'hC0DE_0008, 32'h0C, 1};
    tbl[10] = '{0, 0, 32'h0C, 32'h0,         32'h0C, 0};
    tbl[11] = '{1, 1, 32'h10, 32'hC0DE_000C, 32'h10, 1};
    tbl[12] = '{0, 0, 32'h10, 32'hC0DE_000C, 32'h10, 1};
    tbl[13] = '{0, 1, 32'h14, 32'hC0DE_0010, 32'h14, 1};

    RESET = 1; STALL = 0; BRANCH_TAKEN = 0; BRANCH_TARGET = 0;
    IMEM_VALID = 0; IMEM_DATA = 0;
    mem_busy = 0; rand_lat = 0; mem_lat = 1; mem_cnt = 0; mem_a = 0;
    model_step(1, 0, 0, 32'h0, 0, 32'h0);
    @(posedge CLOCK);
    @(negedge CLOCK);
    tick(1, 0, 0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("vec%0d_req", i), {31'b0, IMEM_REQ}, tbl[i].e_req);
      chk($sformatf("vec%0d_addr", i), IMEM_ADDR, tbl[i].e_addr);
      chk($sformatf("vec%0d_instr", i), Instruction_Out, tbl[i].e_ins);
      chk($sformatf("vec%0d_pc4", i), PCPlus4_Out, tbl[i].e_pc4);
      chk($sformatf("vec%0d_valid", i), {31'b0, VALID_Out}, tbl[i].e_val);
      tick(0, tbl[i].stall, 0, 32'h0);
    end

    // redirect during a 3-cycle fetch; stale response must be dropped
    mem_lat = 3;
    wait_req();
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 1, 32'h0000_0043);
    chk("br_wait_valid", {31'b0, VALID_Out}, 32'h0);
    chk("br_wait_instr", Instruction_Out, 32'h0);
    chk("br_wait_addr", IMEM_ADDR, 32'h40);
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 0, 32'h0);
    chk("br_refetch_req", {31'b0, IMEM_REQ}, 32'h1);
    chk("br_refetch_addr", IMEM_ADDR, 32'h40);
    chk("br_drop_valid", {31'b0, VALID_Out}, 32'h0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 32'h0);
    chk("br_tgt_instr", Instruction_Out, 32'hC0DE_0040);
    chk("br_tgt_pc4", PCPlus4_Out, 32'h44);

    // redirect + stall + response in the same cycle
    mem_lat = 1;
    wait_req();
    tick(0, 0, 0, 32'h0);
    tick(0, 1, 1, 32'h0000_0100);
    chk("brst_req", {31'b0, IMEM_REQ}, 32'h1);
    chk("brst_addr", IMEM_ADDR, 32'h100);
    chk("brst_valid", {31'b0, VALID_Out}, 32'h0);
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 0, 32'h0);
    chk("brst_instr", Instruction_Out, 32'hC0DE_0100);
    chk("brst_pc4", PCPlus4_Out, 32'h104);

    // PC wrap at the top of the address space
    mem_lat = 2;
    wait_req();
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 1, 32'hFFFF_FFFF);
    tick(0, 0, 0, 32'h0);
    chk("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    mem_lat = 1;
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 0, 32'h0);
    chk("wrap_pc4", PCPlus4_Out, 32'h0);
    chk("wrap_valid", {31'b0, VALID_Out}, 32'h1);
    chk("wrap_next_addr", IMEM_ADDR, 32'h0);

    // reset while parked in HOLD
    wait_req();
    tick(0, 0, 0, 32'h0);
    tick(0, 1, 0, 32'h0);
    tick(0, 1, 0, 32'h0);
    tick(1, 1, 0, 32'h0);
    chk("rst_req", {31'b0, IMEM_REQ}, 32'h1);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    chk("rst_instr", Instruction_Out, 32'h0);
    chk("rst_pc4", PCPlus4_Out, 32'h0);
    chk("rst_valid", {31'b0, VALID_Out}, 32'h0);
`ifdef IF_PERF_COUNTERS_EN
    chk("rst_fetch_count", FETCH_COUNT, 32'h0);
    chk("rst_bubble_count", BUBBLE_COUNT, 32'h0);
`endif

    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      bit r, s, b;
      r = ($urandom % 400) == 0;
      s = ($urandom % 4) == 0;
      b = !m_need && (($urandom % 8) == 0);
      tick(r, s, b, $urandom);
    end
    model_cmp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
